// File: rtl/word_led_reader_pkg.sv
// Shared definitions for the word LED read-back path.
//   WORD_W    default captured word width
//   NIBBLE_W  width of one displayed LED nibble
//   state_e   display FSM encoding (ST_IDLE / ST_SHOW)
package word_led_reader_pkg;

   localparam int WORD_W   = 32;
   localparam int NIBBLE_W = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SHOW = 1'b1
   } state_e;

endpackage : word_led_reader_pkg

// File: rtl/word_led_reader_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, hold-time debounce counter and
// rising-edge detector producing a registered one-cycle step pulse.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   raw    in   raw asynchronous button level (1 = pressed)
//   step   out  one-cycle pulse when the debounced level goes 0 -> 1
module word_led_reader_btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic step
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic             stable_prev_q, stable_prev_d;
   logic             step_q, step_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state logic for synchronizer, debounce counter and edge detector.
   always_comb begin
      sync1_d       = raw;
      sync2_d       = sync1_q;
      stable_d      = stable_q;
      cnt_d         = CNT_ZERO;
      // The counter only advances while the synced level disagrees with the
      // accepted level; any agreement (a glitch ending) restarts the hold time.
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = CNT_ZERO;
         end else begin
            cnt_d    = cnt_q + CNT_ONE;
         end
      end else begin
         cnt_d = CNT_ZERO;
      end
      stable_prev_d = stable_q;
      step_d        = stable_q & ~stable_prev_q;
   end

   // Debounce state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         step_q        <= 1'b0;
         cnt_q         <= CNT_ZERO;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         stable_q      <= stable_d;
         stable_prev_q <= stable_prev_d;
         step_q        <= step_d;
         cnt_q         <= cnt_d;
      end
   end

   assign step = step_q;

endmodule : word_led_reader_btn_debounce

// File: rtl/word_led_reader.sv
// Read-back of a captured register word on four LEDs, one nibble at a time,
// stepped by a debounced push-button.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   load     in   capture strobe: latch data, restart at nibble 0
//   data     in   word to capture (sampled only with load)
//   btn_next in   raw push-button advancing the displayed nibble
//   led      out  displayed nibble (0 while idle)
//   led_idx  out  index of displayed nibble (0 = bits 3:0)
//   valid    out  high while a captured word is shown
//   done     out  one-cycle pulse when the display wraps back to nibble 0
module word_led_reader
   import word_led_reader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int WIDTH           = WORD_W
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 load,
   input  logic [WIDTH-1:0]                     data,
   input  logic                                 btn_next,
   output logic [NIBBLE_W-1:0]                  led,
   output logic [$clog2(WIDTH/NIBBLE_W)-1:0]    led_idx,
   output logic                                 valid,
   output logic                                 done
);

   localparam int IDX_W = $clog2(WIDTH / NIBBLE_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH / NIBBLE_W - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    shadow_q, shadow_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NIBBLE_W-1:0] led_q, led_d;
   logic                valid_q, valid_d;
   logic                done_q, done_d;
   logic                step_s;

   word_led_reader_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_next),
      .step  (step_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: any load enters (or stays in) SHOW; only reset leaves it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               state_d = ST_SHOW;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHOW: state_d = ST_SHOW;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs and datapath next values.
   always_comb begin
      shadow_d = shadow_q;
      idx_d    = idx_q;
      done_d   = 1'b0;
      // Load has priority over a coincident step, which is simply dropped.
      if (load) begin
         shadow_d = data;
         idx_d    = IDX_ZERO;
      end else if ((state_q == ST_SHOW) && step_s) begin
         if (idx_q == IDX_LAST) begin
            idx_d  = IDX_ZERO;
            done_d = 1'b1;
         end else begin
            idx_d  = idx_q + IDX_ONE;
         end
      end else begin
         idx_d = idx_q;
      end
      // LED and valid are computed from next values so they land on the same
      // edge as the capture/step that changes them.
      valid_d = (state_d == ST_SHOW);
      if (valid_d) begin
         led_d = shadow_d[{idx_d, 2'b00} +: NIBBLE_W];
      end else begin
         led_d = {NIBBLE_W{1'b0}};
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_q <= {WIDTH{1'b0}};
         idx_q    <= IDX_ZERO;
         led_q    <= {NIBBLE_W{1'b0}};
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         idx_q    <= idx_d;
         led_q    <= led_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
      end
   end

   assign led     = led_q;
   assign led_idx = idx_q;
   assign valid   = valid_q;
   assign done    = done_q;

endmodule : word_led_reader
